// File: rtl/led_word_shifter_if.sv
// Control/data bundle between the LED frame sequencer and led_word_shifter.
// The brightness signal exists only when LED_BRIGHTNESS_EN is defined.
interface led_word_shifter_if #(
  parameter int CHANNELS  = 3,
  parameter int CHAN_BITS = 8,
  parameter int COUNT_W   = 12
);
  localparam int W    = CHANNELS * CHAN_BITS;
  localparam int BL_W = $clog2(W + 1);

  logic                    load;
  logic                    shift;
  logic                    frame_end;
  logic [4*CHANNELS-1:0]   base_color;
  logic [COUNT_W-1:0]      led_index;
  logic [COUNT_W-1:0]      num_leds;
  logic [1:0]              mode;
`ifdef LED_BRIGHTNESS_EN
  logic [1:0]              brightness;
`endif
  logic                    bit_out;
  logic [BL_W-1:0]         bits_left;
  logic                    word_done;

  modport master (
    output load, shift, frame_end, base_color, led_index, num_leds, mode,
`ifdef LED_BRIGHTNESS_EN
    output brightness,
`endif
    input  bit_out, bits_left, word_done
  );

  modport slave (
    input  load, shift, frame_end, base_color, led_index, num_leds, mode,
`ifdef LED_BRIGHTNESS_EN
    input  brightness,
`endif
    output bit_out, bits_left, word_done
  );
endinterface

// File: rtl/led_word_shifter.sv
// Per-LED colour-word composer and MSB-first serialiser with chase/rotate animation.
// Optional feature: LED_BRIGHTNESS_EN adds per-nibble right-shift dimming.
module led_word_shifter #(
  parameter int CHANNELS  = 3,
  parameter int CHAN_BITS = 8,
  parameter int COUNT_W   = 12,
  parameter logic [CHANNELS*CHAN_BITS-1:0] DEFAULT_WORD =
    (CHANNELS*CHAN_BITS)'({CHANNELS{8'h0F}})
) (
  input  logic                  clk,
  input  logic                  reset,
  led_word_shifter_if.slave     io_bus
);
  localparam int W    = CHANNELS * CHAN_BITS;
  localparam int BL_W = $clog2(W + 1);
  localparam int RP_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [W-1:0]          r_word;
  logic [BL_W-1:0]       r_bits_left;
  logic                  r_word_done;
  logic [COUNT_W-1:0]    r_chase_pos;
  logic [RP_W-1:0]       r_rot_pos;

  logic [W-1:0]          w_word;
  logic [3:0]            w_base [CHANNELS];
  logic [4*CHANNELS-1:0] w_idx_ext;
  logic                  w_chase_hit;

  assign w_idx_ext   = (4*CHANNELS)'(io_bus.led_index);
  assign w_chase_hit = (io_bus.led_index == r_chase_pos);

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [3:0]           w_idx_nib;
      logic [3:0]           w_rot_nib;
      logic [3:0]           w_mode_nib;
      logic [3:0]           w_nib;
      logic [RP_W:0]        w_rot_sum;
      logic [RP_W-1:0]      w_rot_idx;
      logic [CHAN_BITS-1:0] w_field;

      // Channel 0 sits in the most significant nibble of base_color.
      assign w_base[gi]  = io_bus.base_color[4*(CHANNELS-1-gi) +: 4];
      assign w_idx_nib   = w_idx_ext[4*(CHANNELS-1-gi) +: 4];
      assign w_rot_sum   = (RP_W+1)'(gi) + {1'b0, r_rot_pos};
      assign w_rot_idx   = (w_rot_sum >= (RP_W+1)'(CHANNELS))
                         ? RP_W'(w_rot_sum - (RP_W+1)'(CHANNELS))
                         : RP_W'(w_rot_sum);
      assign w_rot_nib   = w_base[w_rot_idx];

      always_comb begin
        case (io_bus.mode)
          2'd0:    w_mode_nib = w_base[gi];
          2'd1:    w_mode_nib = w_base[gi] + w_idx_nib;
          2'd2:    w_mode_nib = w_chase_hit ? w_base[gi] : 4'h0;
          default: w_mode_nib = w_rot_nib;
        endcase
      end

`ifdef LED_BRIGHTNESS_EN
      assign w_nib = w_mode_nib >> io_bus.brightness;
`else
      assign w_nib = w_mode_nib;
`endif

      always_comb begin
        w_field                   = '0;
        w_field[CHAN_BITS-1 -: 4] = w_nib;
      end

      assign w_word[W-1-gi*CHAN_BITS -: CHAN_BITS] = w_field;
    end
  endgenerate

  // Load has priority over shift; frame_end updates animation after the word is composed.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_word      <= DEFAULT_WORD;
      r_bits_left <= '0;
      r_word_done <= 1'b0;
      r_chase_pos <= '0;
      r_rot_pos   <= '0;
    end else begin
      r_word_done <= 1'b0;
      if (io_bus.load) begin
        r_word      <= w_word;
        r_bits_left <= BL_W'(W);
      end else if (io_bus.shift) begin
        r_word <= {r_word[W-2:0], r_word[W-1]};
        if (r_bits_left != '0) begin
          r_bits_left <= r_bits_left - BL_W'(1);
          if (r_bits_left == BL_W'(1))
            r_word_done <= 1'b1;
        end
      end
      if (io_bus.frame_end) begin
        r_chase_pos <= (r_chase_pos >= io_bus.num_leds - COUNT_W'(1))
                     ? '0 : r_chase_pos + COUNT_W'(1);
        r_rot_pos   <= (r_rot_pos == RP_W'(CHANNELS-1))
                     ? '0 : r_rot_pos + RP_W'(1);
      end
    end
  end

  assign io_bus.bit_out   = r_word[W-1];
  assign io_bus.bits_left = r_bits_left;
  assign io_bus.word_done = r_word_done;
endmodule

// File: tb/tb_led_word_shifter.sv
// Directed + randomized bench for led_word_shifter against a word-level reference model.
// Brightness steps are included when LED_BRIGHTNESS_EN is defined.
module tb_led_word_shifter;
  localparam int C  = 3;
  localparam int CB = 8;
  localparam int CW = 12;
  localparam int W  = C * CB;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  led_word_shifter_if #(.CHANNELS(C), .CHAN_BITS(CB), .COUNT_W(CW)) bus ();

  led_word_shifter #(.CHANNELS(C), .CHAN_BITS(CB), .COUNT_W(CW)) dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: the word plus how far along it the stream has advanced.
  logic [W-1:0] m_word;
  int           m_pos;
  int           m_left;
  int           m_chase;
  int           m_rot;
  bit           m_done;

  function automatic logic [W-1:0] compose(int base, int idx, int mode, int chase,
                                           int rot, int br);
    logic [W-1:0] word = '0;
    for (int k = 0; k < C; k++) begin
      int sh = 4 * (C - 1 - k);
      int b  = (base >> sh) & 15;
      int n;
      case (mode)
        0: n = b;
        1: n = (b + ((idx >> sh) & 15)) & 15;
        2: n = (idx == chase) ? b : 0;
        default: n = (base >> (4 * (C - 1 - ((k + rot) % C)))) & 15;
      endcase
      n = n >> br;
      word = word | (W'(n) << (CB * (C - 1 - k) + CB - 4));
    end
    return word;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit ld, input bit sh, input bit fe, input bit rs);
    int br = 0;
    bus.load = ld; bus.shift = sh; bus.frame_end = fe; reset = rs;
    @(posedge clk);
`ifdef LED_BRIGHTNESS_EN
    br = int'(bus.brightness);
`endif
    m_done = 1'b0;
    if (rs) begin
      m_word = 24'h0F0F0F; m_pos = 0; m_left = 0; m_chase = 0; m_rot = 0;
    end else begin
      if (ld) begin
        m_word = compose(int'(bus.base_color), int'(bus.led_index), int'(bus.mode),
                         m_chase, m_rot, br);
        m_pos  = 0;
        m_left = W;
      end else if (sh) begin
        m_pos++;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) m_done = 1'b1;
        end
      end
      if (fe) begin
        m_chase = (m_chase >= int'(bus.num_leds) - 1) ? 0 : m_chase + 1;
        m_rot   = (m_rot == C - 1) ? 0 : m_rot + 1;
      end
    end
    #1;
    bus.load = 1'b0; bus.shift = 1'b0; bus.frame_end = 1'b0; reset = 1'b0;
    chk("bit_out",   32'(bus.bit_out),   32'(m_word[W-1-(m_pos % W)]));
    chk("bits_left", 32'(bus.bits_left), 32'(m_left));
    chk("word_done", 32'(bus.word_done), 32'(m_done));
  endtask

  task automatic read_word(input string tag, output logic [W-1:0] w);
    w = '0;
    for (int i = 0; i < W; i++) begin
      w = {w[W-2:0], bus.bit_out};
      step(1'b0, 1'b1, 1'b0, 1'b0);
    end
    $display("word %s = 0x%06h", tag, w);
  endtask

  logic [W-1:0] w;

  initial begin
    bus.load = 1'b0; bus.shift = 1'b0; bus.frame_end = 1'b0;
    bus.base_color = '0; bus.led_index = '0; bus.num_leds = 12'd1; bus.mode = 2'd0;
`ifdef LED_BRIGHTNESS_EN
    bus.brightness = 2'd0;
`endif
    m_word = 24'h0F0F0F; m_pos = 0; m_left = 0; m_chase = 0; m_rot = 0; m_done = 1'b0;

    // Reset state and default word
    step(0, 0, 0, 1);
    chk("rst_bit_out", 32'(bus.bit_out), 32'd0);
    chk("rst_bits_left", 32'(bus.bits_left), 32'd0);
    chk("rst_word_done", 32'(bus.word_done), 32'd0);
    read_word("reset", w);
    chk("rst_word", 32'(w), 32'h0F0F0F);
    chk("rst_no_done", 32'(bus.word_done), 32'd0);

    // Mode 0 static
    bus.mode = 2'd0; bus.base_color = 12'hA53;
    step(1, 0, 0, 0);
    chk("m0_left_load", 32'(bus.bits_left), 32'd24);
    read_word("mode0", w);
    chk("m0_word", 32'(w), 32'hA05030);
    chk("m0_done", 32'(bus.word_done), 32'd1);
    chk("m0_repeat_msb", 32'(bus.bit_out), 32'd1);
    step(0, 1, 0, 0);
    chk("m0_no_strobe", 32'(bus.word_done), 32'd0);
    chk("m0_left_zero", 32'(bus.bits_left), 32'd0);

    // Mode 1 gradient with nibble wrap
    bus.mode = 2'd1; bus.base_color = 12'h111; bus.led_index = 12'h1F3;
    step(1, 0, 0, 0);
    read_word("mode1", w);
    chk("m1_word", 32'(w), 32'h200040);

    // Mode 2 chase over a 3-LED chain
    step(0, 0, 0, 1);
    bus.mode = 2'd2; bus.num_leds = 12'd3; bus.base_color = 12'hFFF;
    bus.led_index = 12'd0; step(1, 0, 0, 0); read_word("chase0_i0", w);
    chk("m2_i0", 32'(w), 32'hF0F0F0);
    bus.led_index = 12'd1; step(1, 0, 0, 0); read_word("chase0_i1", w);
    chk("m2_i1_off", 32'(w), 32'h000000);
    step(0, 0, 1, 0);
    step(1, 0, 0, 0); read_word("chase1_i1", w);
    chk("m2_i1_on", 32'(w), 32'hF0F0F0);
    step(0, 0, 1, 0); step(0, 0, 1, 0);
    bus.led_index = 12'd0; step(1, 0, 0, 0); read_word("chase_wrap", w);
    chk("m2_wrap", 32'(w), 32'hF0F0F0);

    // Mode 3 rotate, load+shift and load+frame_end collisions
    step(0, 0, 0, 1);
    bus.mode = 2'd3; bus.base_color = 12'h123;
    step(0, 0, 1, 0);
    step(1, 0, 0, 0); read_word("rot1", w);
    chk("m3_word", 32'(w), 32'h203010);
    step(1, 1, 0, 0);
    chk("m3_ld_sh_left", 32'(bus.bits_left), 32'd24);
    read_word("rot1_ldsh", w);
    chk("m3_ld_sh_word", 32'(w), 32'h203010);
    step(1, 0, 1, 0); read_word("rot1_ldfe", w);
    chk("m3_ld_fe_word", 32'(w), 32'h203010);

`ifdef LED_BRIGHTNESS_EN
    bus.mode = 2'd0; bus.base_color = 12'h8F4; bus.brightness = 2'd2;
    step(1, 0, 0, 0); read_word("bright2", w);
    chk("br_word", 32'(w), 32'h203010);
    bus.brightness = 2'd0;
`endif

    // Reset mid-word
    bus.mode = 2'd0; bus.base_color = 12'hFFF;
    step(1, 0, 0, 0);
    for (int i = 0; i < 14; i++) step(0, 1, 0, 0);
    chk("mid_left10", 32'(bus.bits_left), 32'd10);
    step(0, 0, 0, 1);
    chk("mid_rst_bit", 32'(bus.bit_out), 32'd0);
    chk("mid_rst_left", 32'(bus.bits_left), 32'd0);
    chk("mid_rst_done", 32'(bus.word_done), 32'd0);
    $display("reset mid-word applied");

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus.mode       = 2'($urandom_range(0, 3));
      bus.base_color = 12'($urandom);
      bus.num_leds   = 12'($urandom_range(1, 5));
      bus.led_index  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : 12'($urandom_range(0, 6));
`ifdef LED_BRIGHTNESS_EN
      bus.brightness = 2'($urandom_range(0, 3));
`endif
      step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end
    $display("random phase done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/led_word_shifter.md
# led_word_shifter

Parametrised per-LED colour-word generator and serialiser for the addressable-LED chain driver. On each `load` it composes one CHANNELS×CHAN_BITS control word from the switch colour nibbles, the current LED index and a per-frame animation state. It then shifts the word out MSB-first, one bit per `shift` pulse, to the bit-timing encoder. It adds selectable animation modes, a frame-advanced chase/rotate state and a word-complete strobe.

## Interface
- CHANNELS, 3: colour channels per LED (3 = GRB, 4 = GRBW); legal 3..4
- CHAN_BITS, 8: bits per channel; ≥4
- COUNT_W, 12: LED index / count width
- DEFAULT_WORD, {CHANNELS{8'h0F}} (truncated/extended to W): reset word
- Derived: W = CHANNELS*CHAN_BITS; BL_W = clog2(W+1)
- Clocking: reset, synchronous, active-high; clock clk.
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- load  in  1  pulse: compose word for `led_index` into shift register
- shift  in  1  pulse: rotate register left one bit
- frame_end  in  1  pulse: advance animation state (once per frame)
- base_color  in  4*CHANNELS  colour nibbles; channel 0 (first sent) in MS nibble
- led_index  in  COUNT_W  index of LED being loaded
- num_leds  in  COUNT_W  LEDs in chain; ≥1
- mode  in  2  0 static, 1 gradient, 2 chase, 3 rotate
- brightness  in  2  right-shift per nibble (only with LED_BRIGHTNESS_EN)
- bit_out  out  1  register MSB
- bits_left  out  BL_W  bits remaining in current word
- word_done  out  1  one-cycle strobe after last bit of word shifted

## Operation
- Channel k field = {nib_k, (CHAN_BITS-4)'b0}; fields concatenated k=0 first (MSB).
- nib_k by mode (4-bit, wrap mod 16):
  - 0: base_k.
  - 1: base_k + idx nibble (CHANNELS-1-k); led_index zero-extended/truncated to 4*CHANNELS bits.
  - 2: base_k if led_index == chase_pos, else 0.
  - 3: base nibbles rotated toward MSB by rot_pos channels (nib_k = base_((k+rot_pos) mod CHANNELS)).
- chase_pos (COUNT_W): +1 on frame_end; wraps to 0 when == num_leds-1 (or ≥, if num_leds shrank).
- rot_pos: +1 on frame_end; wraps to 0 at CHANNELS-1. Both advance regardless of mode.
- load: reg ← composed word; bits_left ← W.
- shift (no load): reg ← {reg[W-2:0], reg[W-1]}. If bits_left > 0, decrement; on 1→0, word_done = 1 next cycle. With bits_left == 0, shift still rotates (repeat same word); no strobe.
- load and shift same cycle: load wins; shift ignored.
- load and frame_end same cycle: word uses pre-increment chase_pos/rot_pos.
- Reset mid-word: reg ← DEFAULT_WORD; bits_left, word_done, chase_pos, rot_pos ← 0.

## Timing
- All state registered on posedge clk; bit_out = reg[W-1] combinationally from register (valid cycle after load/shift).
- Load-to-first-bit latency: 1 cycle. word_done: registered, high exactly 1 cycle, the cycle after the W-th shift.
- Reset values: bit_out = DEFAULT_WORD[W-1], bits_left = 0, word_done = 0.
- Back-to-back shifts every cycle supported; load may follow word_done immediately.

## Configuration
- LED_BRIGHTNESS_EN defined: `brightness` port present; nib_k ← nib_k >> brightness after mode selection.
- Undefined: port absent; nibbles unscaled. All other behaviour identical.

## Test plan
- Reset (CHANNELS=3, CHAN_BITS=8) -> bit_out=0, bits_left=0, word_done=0; 24 shifts reproduce 0x0F0F0F, no word_done.
- mode 0, base 0xA53, load, 24 shifts -> bits 0xA05030 MSB-first; bits_left 24→0; word_done one cycle after 24th shift; 25th shift repeats MSB 1, no strobe.
- mode 1, base 0x111, led_index 0x1F3 -> word 0x200040 (0x1+0xF wraps to 0).
- mode 2, num_leds 3, base 0xFFF: loads at index 0 -> 0xF0F0F0, index 1 -> 0; one frame_end then index 1 -> 0xF0F0F0; three frame_ends total -> chase_pos 0.
- mode 3, base 0x123, one frame_end -> word 0x203010; load+shift same cycle -> loaded word, bits_left 24.
- LED_BRIGHTNESS_EN, base 0x8F4, brightness 2 -> 0x203010; reset asserted at bits_left 10 -> defaults next cycle.
